// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter.
// Takes a W-bit word over a valid/ready handshake and sends it one bit per clock,
// with frame and last-bit strobes. Back-to-back words leave no idle gap.
// Every output comes straight from a flop, so no input reaches an output combinationally.
module piso_tx #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rn,
    input  logic [W-1:0] din,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         sout,
    output logic         sframe,
    output logic         slast
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [W-1:0]   r_shift;
    logic [W-1:0]   w_shiftNext;
    logic [W-1:0]   w_shifted;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cntNext;
    logic [CW-1:0]  w_cntInc;
    logic           r_sout;
    logic           r_sframe;
    logic           r_slast;
    logic           r_ready;
    logic           w_soutNext;
    logic           w_sframeNext;
    logic           w_slastNext;
    logic           w_readyNext;
    logic           w_accept;

    // A word is taken only when the source offers one and we advertised readiness.
    assign w_accept = load_valid & r_ready;
    assign w_cntInc = r_cnt + CW'(1);

    // Move the shift register one place toward the transmitting end.
    always_comb begin
        if (MSB_FIRST) begin
            w_shifted = {r_shift[W-2:0], 1'b0};
        end else begin
            w_shifted = {1'b0, r_shift[W-1:1]};
        end
    end

    // Next-state and registered-output decode; idle values are the defaults.
    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shift;
        w_cntNext    = r_cnt;
        w_soutNext   = 1'b0;
        w_sframeNext = 1'b0;
        w_slastNext  = 1'b0;
        w_readyNext  = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stateNext  = SHIFT;
                    w_shiftNext  = din;
                    w_cntNext    = '0;
                    w_soutNext   = MSB_FIRST ? din[W-1] : din[0];
                    w_sframeNext = 1'b1;
                    w_readyNext  = 1'b0;
                end
            end
            SHIFT: begin
                if (r_cnt != LAST_IDX) begin
                    w_shiftNext  = w_shifted;
                    w_cntNext    = w_cntInc;
                    w_soutNext   = MSB_FIRST ? w_shifted[W-1] : w_shifted[0];
                    w_sframeNext = 1'b1;
                    w_slastNext  = (w_cntInc == LAST_IDX);
                    w_readyNext  = (w_cntInc == LAST_IDX);
                end else if (w_accept) begin
                    w_shiftNext  = din;
                    w_cntNext    = '0;
                    w_soutNext   = MSB_FIRST ? din[W-1] : din[0];
                    w_sframeNext = 1'b1;
                    w_readyNext  = 1'b0;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State, datapath and output flops; reset drops everything at once.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_sout   <= 1'b0;
            r_sframe <= 1'b0;
            r_slast  <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_shift  <= w_shiftNext;
            r_cnt    <= w_cntNext;
            r_sout   <= w_soutNext;
            r_sframe <= w_sframeNext;
            r_slast  <= w_slastNext;
            r_ready  <= w_readyNext;
        end
    end

    assign load_ready = r_ready;
    assign sout       = r_sout;
    assign sframe     = r_sframe;
    assign slast      = r_slast;

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: one MSB-first and one LSB-first instance share all inputs
// and are compared every cycle against a position-based model plus a word scoreboard.
module tb_piso_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rn = 1'b0;
    logic         loadValid = 1'b0;
    logic [W-1:0] din = '0;

    logic readyM, soutM, frameM, lastM;
    logic readyL, soutL, frameL, lastL;

    int checks = 0;
    int errors = 0;

    // Model: position of the bit on the wire (-1 = nothing being sent).
    int           mIdx = -1;
    bit           mPrimed = 1'b0;
    logic [W-1:0] mWord = '0;

    // Scoreboard of accepted words and deserialised words from each instance.
    logic [W-1:0] sentQ[$];
    logic [W-1:0] rxM = '0;
    logic [W-1:0] rxL = '0;

    piso_tx #(.W(W), .MSB_FIRST(1'b1)) dutMsb (
        .clk        (clk),
        .rn         (rn),
        .din        (din),
        .load_valid (loadValid),
        .load_ready (readyM),
        .sout       (soutM),
        .sframe     (frameM),
        .slast      (lastM)
    );

    piso_tx #(.W(W), .MSB_FIRST(1'b0)) dutLsb (
        .clk        (clk),
        .rn         (rn),
        .din        (din),
        .load_valid (loadValid),
        .load_ready (readyL),
        .sout       (soutL),
        .sframe     (frameL),
        .slast      (lastL)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic modelReady();
        return mPrimed && (mIdx < 0 || mIdx == W - 1);
    endfunction

    function automatic logic modelBit(input bit msbFirst);
        if (mIdx < 0) return 1'b0;
        return msbFirst ? mWord[W-1-mIdx] : mWord[mIdx];
    endfunction

    task automatic modelReset();
        mIdx = -1;
        mPrimed = 1'b0;
        sentQ.delete();
        rxM = '0;
        rxL = '0;
    endtask

    task automatic checkAll();
        logic [W-1:0] expWord;
        checkOutput("readyMsb", readyM, modelReady());
        checkOutput("readyLsb", readyL, modelReady());
        checkOutput("frameMsb", frameM, mIdx >= 0);
        checkOutput("frameLsb", frameL, mIdx >= 0);
        checkOutput("lastMsb",  lastM,  mIdx == W - 1);
        checkOutput("lastLsb",  lastL,  mIdx == W - 1);
        checkOutput("soutMsb",  soutM,  modelBit(1'b1));
        checkOutput("soutLsb",  soutL,  modelBit(1'b0));
        if (frameM) rxM = {rxM[W-2:0], soutM};
        if (frameL) rxL = {soutL, rxL[W-1:1]};
        if (lastM || lastL) begin
            checkOutput("wordPending", sentQ.size() > 0, 1'b1);
            if (sentQ.size() > 0) begin
                expWord = sentQ.pop_front();
                checkOutput("wordMsb", rxM, expWord);
                checkOutput("wordLsb", rxL, expWord);
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model at the rising edge, check at the next falling edge.
    task automatic applyStimulus(input logic valid, input logic [W-1:0] data);
        logic accept;
        loadValid = valid;
        din = data;
        accept = valid && modelReady();
        @(posedge clk);
        if (mIdx >= 0 && mIdx < W - 1) begin
            mIdx++;
        end else if (accept) begin
            mWord = data;
            mIdx = 0;
            sentQ.push_back(data);
        end else begin
            mIdx = -1;
        end
        mPrimed = 1'b1;
        @(negedge clk);
        checkAll();
    endtask

    // Asynchronous reset asserted mid-cycle, checked immediately and while held.
    task automatic doReset();
        rn = 1'b0;
        loadValid = 1'b0;
        #1;
        modelReset();
        checkAll();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            checkAll();
        end
        rn = 1'b1;
    endtask

    // Accept one word, then hold valid with changing din until the last bit, then offer nextWord.
    task automatic sendBusy(input logic [W-1:0] first, input logic [W-1:0] nextWord, input logic hold);
        applyStimulus(1'b1, first);
        for (int i = 0; i < W - 1; i++) begin
            applyStimulus(hold, W'($urandom));
        end
        applyStimulus(hold, nextWord);
    endtask

    initial begin
        @(negedge clk);
        doReset();
        repeat (3) applyStimulus(1'b0, W'($urandom));

        // Single words with idle time afterwards.
        applyStimulus(1'b1, 8'hA5);
        repeat (10) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h01);
        repeat (10) applyStimulus(1'b0, 8'hFF);

        // Back-to-back A5 then 3C with valid held high and din busy in between.
        sendBusy(8'hA5, 8'h3C, 1'b1);
        repeat (W - 1) applyStimulus(1'b0, 8'h00);
        repeat (4) applyStimulus(1'b0, 8'h00);

        // Busy hold on F0 followed by the word present on the last-bit cycle.
        sendBusy(8'hF0, 8'h5A, 1'b1);
        repeat (W + 4) applyStimulus(1'b0, 8'h00);

        // Reset in the middle of a frame of FF.
        applyStimulus(1'b1, 8'hFF);
        repeat (3) applyStimulus(1'b0, 8'h00);
        #2;
        doReset();
        repeat (W + 3) applyStimulus(1'b0, 8'h00);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, W'($urandom));
            end
        end
        repeat (W + 2) applyStimulus(1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
